// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and defaults for the external program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  // Default RAM depth and the address width that covers it
  localparam int RAM_BYTES_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT    = 4;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_STB = 3'd1,
    ST_WRITE    = 3'd2,
    ST_ACK      = 3'd3,
    ST_FULL     = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_loader_sync2.sv
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for asynchronous single-bit inputs,
//               synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability time to resolve
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Host-driven program loader. Holds the CPU in reset while the
//               host streams bytes over a 4-phase strobe/ack handshake and
//               writes them to consecutive RAM addresses from 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RAM_BYTES = RAM_BYTES_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              prog_strobe,
  input  logic [7:0]        prog_data,
  output logic              prog_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  logic mode_s;
  logic stb_s;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] count_q,     count_d;
  logic [7:0]        wdata_q,     wdata_d;
  logic              done_q,      done_d;
  logic              ovf_q,       ovf_d;
  logic              ack_q,       ack_d;
  logic              we_q,        we_d;
  logic              hold_q,      hold_d;

  sync2 u_sync_mode (
    .clk (clk),
    .rst (rst),
    .d   (prog_mode),
    .q   (mode_s)
  );

  sync2 u_sync_stb (
    .clk (clk),
    .rst (rst),
    .d   (prog_strobe),
    .q   (stb_s)
  );

  // Next-state, counter and flag logic; strobes in FULL are acked via ACK
  // but never reach WRITE, so the RAM is never touched past the last byte
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mode_s) begin
          count_d = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_WAIT_STB;
        end
      end
      ST_WAIT_STB: begin
        if (!mode_s) begin
          state_d = ST_IDLE;
        end else if (stb_s) begin
          wdata_d = prog_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!mode_s) begin
          state_d = ST_IDLE;
        end else if (!stb_s) begin
          if (done_q) begin
            state_d = ST_FULL;
          end else if (count_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_FULL;
          end else begin
            count_d = count_q + ADDR_W'(1);
            state_d = ST_WAIT_STB;
          end
        end
      end
      ST_FULL: begin
        if (!mode_s) begin
          state_d = ST_IDLE;
        end else if (stb_s) begin
          ovf_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered copies decoded from the upcoming state
  always_comb begin
    ack_d  = (state_d == ST_ACK);
    we_d   = (state_d == ST_WRITE);
    hold_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wdata_q <= 8'h00;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
    end
  end

  assign prog_ack  = ack_q;
  assign ram_addr  = count_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader with randomized host
//               sessions checked against a simple load-session model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_mode;
  logic       prog_strobe;
  logic [7:0] prog_data;
  logic       prog_ack;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       cpu_hold;
  logic       load_done;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed writes as {addr, data}, and count of write pulses wider than 1
  logic [11:0] wlog[$];
  int          we_multi = 0;
  logic        prev_we  = 1'b0;
  logic [7:0]  exp_data[16];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk         (clk),
    .rst         (rst),
    .prog_mode   (prog_mode),
    .prog_strobe (prog_strobe),
    .prog_data   (prog_data),
    .prog_ack    (prog_ack),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .overflow    (overflow)
  );

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_we) wlog.push_back({ram_addr, ram_wdata});
    if (ram_we && prev_we) we_multi++;
    prev_we <= ram_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise prog_mode; cpu_hold must rise on exactly the third edge
  task automatic enter_load();
    prog_mode = 1'b1;
    tick(2);
    check("hold_rise_early", cpu_hold, 0);
    tick(1);
    check("hold_rise", cpu_hold, 1);
    wlog.delete();
  endtask

  // Drop prog_mode; cpu_hold must fall on exactly the third edge
  task automatic leave_load();
    prog_mode = 1'b0;
    tick(2);
    check("hold_fall_early", cpu_hold, 1);
    tick(1);
    check("hold_fall", cpu_hold, 0);
  endtask

  // One full 4-phase handshake; byte index idx decides write vs overflow ack
  task automatic send_byte(input int idx, input logic [7:0] d);
    int we_lat;
    int ack_lat;
    int fall_lat;
    we_lat   = -1;
    ack_lat  = -1;
    fall_lat = -1;
    prog_data   = d;
    prog_strobe = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (ram_we && we_lat < 0) we_lat = c;
      if (prog_ack) begin
        ack_lat = c;
        break;
      end
    end
    check("ack_rise_latency", ack_lat, (idx < 16) ? 4 : 3);
    check("we_latency", we_lat, (idx < 16) ? 3 : -1);
    prog_strobe = 1'b0;
    prog_data   = 8'($urandom);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (!prog_ack) begin
        fall_lat = c;
        break;
      end
    end
    check("ack_fall_latency", fall_lat, 3);
  endtask

  // A complete load session of n bytes checked against the session model
  task automatic run_session(input int n, input bit seq);
    int         exp_w;
    logic [7:0] d;
    exp_w = (n < 16) ? n : 16;
    enter_load();
    for (int i = 0; i < n; i++) begin
      d = seq ? 8'(8'h10 + i) : 8'($urandom);
      if (i < 16) exp_data[i] = d;
      send_byte(i, d);
      tick($urandom_range(0, 3));
    end
    check("write_count", wlog.size(), exp_w);
    for (int i = 0; i < exp_w && i < wlog.size(); i++) begin
      check("write_addr", {20'd0, wlog[i][11:8]}, i);
      check("write_data", {24'd0, wlog[i][7:0]}, {24'd0, exp_data[i]});
    end
    check("load_done", load_done, (n >= 16) ? 1 : 0);
    check("overflow", overflow, (n > 16) ? 1 : 0);
    check("ram_addr_end", ram_addr, (n >= 16) ? 15 : n);
    check("we_pulse_width", we_multi, 0);
    leave_load();
    check("load_done_kept", load_done, (n >= 16) ? 1 : 0);
    check("overflow_kept", overflow, (n > 16) ? 1 : 0);
  endtask

  initial begin
    int got_ack;
    rst         = 1'b1;
    prog_mode   = 1'b0;
    prog_strobe = 1'b0;
    prog_data   = 8'h00;

    // Reset with random inputs: every output stays zero
    for (int k = 0; k < 6; k++) begin
      prog_mode   = 1'($urandom);
      prog_strobe = 1'($urandom);
      prog_data   = 8'($urandom);
      tick(1);
      check("reset_outputs",
            {19'd0, prog_ack, ram_we, cpu_hold, load_done, overflow, ram_addr, ram_wdata}, 0);
    end
    prog_mode   = 1'b0;
    prog_strobe = 1'b0;
    rst         = 1'b0;
    tick(4);

    // Full load with 0x10..0x1F, then a 17th byte that overflows
    run_session(16, 1'b1);
    run_session(17, 1'b1);

    // Early exit, then re-entry restarting at address 0
    run_session(5, 1'b0);
    run_session(3, 1'b0);

    // Abort while in ACK: ack drops within 3 edges, no extra write
    enter_load();
    send_byte(0, 8'($urandom));
    send_byte(1, 8'($urandom));
    prog_data   = 8'($urandom);
    prog_strobe = 1'b1;
    got_ack = 0;
    for (int c = 0; c < 12 && got_ack == 0; c++) begin
      tick(1);
      if (prog_ack) got_ack = 1;
    end
    check("abort_ack_seen", got_ack, 1);
    prog_mode = 1'b0;
    tick(3);
    check("abort_ack_dropped", prog_ack, 0);
    check("abort_hold", cpu_hold, 0);
    tick(3);
    check("abort_write_count", wlog.size(), 3);
    check("abort_load_done", load_done, 0);
    prog_strobe = 1'b0;
    tick(4);

    // Reset during WRITE after the counter has advanced
    enter_load();
    send_byte(0, 8'($urandom));
    send_byte(1, 8'($urandom));
    prog_data   = 8'($urandom);
    prog_strobe = 1'b1;
    got_ack = 0;
    for (int c = 0; c < 12 && got_ack == 0; c++) begin
      tick(1);
      if (ram_we) got_ack = 1;
    end
    check("rst_write_seen", got_ack, 1);
    check("rst_addr_before", ram_addr, 2);
    rst = 1'b1;
    tick(1);
    check("rst_mid_we", ram_we, 0);
    check("rst_mid_addr", ram_addr, 0);
    check("rst_mid_hold", cpu_hold, 0);
    check("rst_mid_ack", prog_ack, 0);
    rst         = 1'b0;
    prog_mode   = 1'b0;
    prog_strobe = 1'b0;
    tick(5);
    check("rst_mid_idle", cpu_hold, 0);

    // Randomized sessions of varying length
    for (int s = 0; s < 5; s++) begin
      run_session($urandom_range(0, 20), 1'b0);
      tick($urandom_range(1, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

External program loader for the 8-bit CPU's 16-byte RAM. While the host holds `prog_mode` high, the loader keeps the CPU in reset and accepts bytes from the host over a 4-phase strobe/ack handshake. It writes each byte to consecutive RAM addresses starting at 0. It is the write-side counterpart of the CPU's RAM fetch path, driven from `ui_in`, and sits in the top level between the pins and the RAM write port.

## Interface

Parameters:
- `RAM_BYTES`, default 16: number of writable RAM locations.
- `ADDR_W`, default 4: RAM address width; must satisfy 2**ADDR_W >= RAM_BYTES.

Ports:
- `clk` input, 1: system clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `prog_mode` input, 1: host level request to enter load mode; asynchronous.
- `prog_strobe` input, 1: host data strobe; asynchronous.
- `prog_data` input, 8: host data byte; stable from `prog_strobe` rise until `prog_ack` rise.
- `prog_ack` output, 1: handshake acknowledge to host.
- `ram_addr` output, ADDR_W: RAM write address.
- `ram_wdata` output, 8: RAM write data.
- `ram_we` output, 1: one-cycle RAM write enable.
- `cpu_hold` output, 1: holds the CPU in reset; ORed into the core reset.
- `load_done` output, 1: all RAM_BYTES locations written.
- `overflow` output, 1: sticky flag; the host sent more than RAM_BYTES bytes.

## Operation

- `prog_mode` and `prog_strobe` each pass through a 2-flop synchronizer. The FSM sees only the synchronized versions, `mode_s` and `stb_s`.
- FSM states: IDLE, WAIT_STB, WRITE, ACK, FULL.
- IDLE:
  - `cpu_hold`=0.
  - When `mode_s`=1: clear the address counter to 0, clear `overflow` and `load_done`, and go to WAIT_STB.
- WAIT_STB:
  - `cpu_hold`=1.
  - When `stb_s`=1: latch `prog_data` into `ram_wdata` and go to WRITE.
- WRITE:
  - `ram_we`=1 for exactly this one cycle, with `ram_addr` = current count.
  - Then go to ACK.
- ACK:
  - `prog_ack`=1.
  - When `stb_s`=0: drop `prog_ack`. If count = RAM_BYTES-1, set `load_done` and go to FULL; otherwise increment count and go to WAIT_STB.
- FULL:
  - `cpu_hold`=1.
  - Further strobes are acknowledged using the same ack rules, but never written. The first such strobe sets `overflow`.
  - `ram_addr` holds RAM_BYTES-1; there is no wrap-around.
- `mode_s` falling:
  - From WAIT_STB, ACK or FULL: go to IDLE on the next edge and drop `prog_ack`.
  - WRITE always completes its one cycle before the FSM leaves it.
  - `load_done` and `overflow` keep their values in IDLE until the next load entry.
- Partial load (mode dropped early): the bytes already written remain in RAM, and `load_done` stays 0.
- `rst` wins over all other conditions:
  - State → IDLE; count → 0.
  - `prog_ack`, `ram_we`, `cpu_hold`, `load_done`, `overflow` → 0.
  - `ram_wdata` → 0x00; both synchronizers → 0.

## Timing

- All outputs are registered.
- Pin rise to FSM response: `prog_strobe` high at edge N → `stb_s` high after N+1 → WRITE entered at N+2 (`ram_we` high from N+2 to N+3) → ACK entered at N+3 (`prog_ack` high from N+3 onward).
- `prog_ack` deasserts 3 edges after `prog_strobe` falls.
- `cpu_hold` asserts 3 edges after `prog_mode` rises and deasserts 3 edges after it falls.
- Minimum byte period is about 7 cycles, limited by the host handshake.

## Structure

- Shared package holds:
  - FSM state enum (IDLE, WAIT_STB, WRITE, ACK, FULL).
  - `RAM_BYTES` default.
- Sub-module `sync2`: 2-flop synchronizer with a synchronous active-high reset. It is instantiated twice and reused elsewhere for `ui_in` inputs.
- The address counter and the FSM live in `prog_loader`.

## Test plan

- Reset: hold `rst` with random inputs → all outputs 0; `ram_wdata`=0x00.
- Full load:
  - Stimulus: `prog_mode`=1, then 16 handshakes with data 0x10..0x1F.
  - Required: each `ram_we` pulse lasts exactly 1 cycle, addresses run 0..15 with matching data, `load_done`=1 after the last ack.
  - After `prog_mode`=0: `cpu_hold` falls 3 cycles later.
- Overflow: 17th strobe after a full load → acked, no `ram_we`, `overflow`=1, `ram_addr` stays 15.
- Early exit: 5 bytes written, then `prog_mode` drops → IDLE, `load_done`=0, `cpu_hold`=0.
  - Re-entering load mode restarts at address 0.
- Mid-handshake abort: `prog_mode` falls while in ACK → `prog_ack`=0 within 3 cycles; no extra write.
- Reset mid-operation: `rst` pulse in WRITE → `ram_we` low on the next cycle, FSM in IDLE, counter at 0.
